vga_pattern_gen: RTL and testbench

Pixel-generation stage directly downstream of the 800x600@60 Hz VGA timing chain (HCounter/VCounter, comparators, sync flip-flops). Consumes the horizontal/vertical counts, the combined display-enable and the active-low sync pulses, and produces registered RGB with the sync pulses delayed to stay pixel-aligned. Provides four selectable test patterns (colour bars, checkerboard, grey ramp, bouncing box), with the pattern switch and box motion applied only at frame boundaries.

---
 rtl/vga_pattern_if.sv | 30 +++
 rtl/vga_pattern_gen.sv | 222 ++++++++++++++++++++++
 tb/tb_vga_pattern_gen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/vga_pattern_if.sv
// Pixel-stage bundle between the VGA timing chain and the pattern generator.
// The timing side (master) drives counts/syncs/mode; the generator (slave) returns RGB and status.
interface vga_pattern_if #(
   parameter int COLOR_W = 4
);
   logic [10:0]        hcount;
   logic [9:0]         vcount;
   logic               de;
   logic               hsync_n;
   logic               vsync_n;
   logic [1:0]         mode;
   logic               mode_load;
   logic [COLOR_W-1:0] red;
   logic [COLOR_W-1:0] green;
   logic [COLOR_W-1:0] blue;
   logic               hsync_out_n;
   logic               vsync_out_n;
   logic [7:0]         frame_count;
   logic [1:0]         active_mode;

   modport master (
      output hcount, vcount, de, hsync_n, vsync_n, mode, mode_load,
      input  red, green, blue, hsync_out_n, vsync_out_n, frame_count, active_mode
   );

   modport slave (
      input  hcount, vcount, de, hsync_n, vsync_n, mode, mode_load,
      output red, green, blue, hsync_out_n, vsync_out_n, frame_count, active_mode
   );
endinterface

// File: rtl/vga_pattern_gen.sv
// Two-stage test-pattern generator for 800x600 VGA: stage 1 decodes every pattern,
// stage 2 muxes by the active mode; syncs ride along so RGB stays pixel-aligned.
module vga_pattern_gen #(
   parameter int H_ACTIVE = 800,
   parameter int V_ACTIVE = 600,
   parameter int BOX_SIZE = 64,
   parameter int COLOR_W  = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   vga_pattern_if.slave  vga
);

   typedef enum logic [1:0] {
      PAT_BARS  = 2'd0,
      PAT_CHECK = 2'd1,
      PAT_RAMP  = 2'd2,
      PAT_BOX   = 2'd3
   } pattern_e;

   typedef struct packed {
      logic [10:0] pos;
      logic        neg;
   } axis_t;

   localparam logic [10:0]        X_MAX  = 11'(H_ACTIVE - BOX_SIZE);
   localparam logic [10:0]        Y_MAX  = 11'(V_ACTIVE - BOX_SIZE);
   localparam logic [10:0]        BOX_W  = 11'(BOX_SIZE);
   localparam logic [10:0]        X_STEP = 11'd4;
   localparam logic [10:0]        Y_STEP = 11'd2;
   localparam logic [COLOR_W-1:0] FULL   = '1;

   // Bounce: a step that would leave [0, lim] reverses direction and steps back instead.
   function automatic axis_t step_axis(input axis_t cur, input logic [10:0] step,
                                       input logic [10:0] lim);
      axis_t nxt;
      nxt = cur;
      if (!cur.neg) begin
         if (cur.pos + step > lim) begin
            nxt.neg = 1'b1;
            nxt.pos = cur.pos - step;
         end else begin
            nxt.pos = cur.pos + step;
         end
      end else begin
         if (cur.pos < step) begin
            nxt.neg = 1'b0;
            nxt.pos = cur.pos + step;
         end else begin
            nxt.pos = cur.pos - step;
         end
      end
      return nxt;
   endfunction

   // Frame-level state
   logic [7:0] frame_q, frame_d;
   pattern_e   active_q, active_d;
   pattern_e   pending_q, pending_d;
   axis_t      box_x_q, box_x_d;
   axis_t      box_y_q, box_y_d;

   // Stage 1: per-pattern decode
   logic               de1_q, hs1_q, vs1_q;
   logic [2:0]         bar1_q, bar_d;
   logic               chk1_q, chk_d;
   logic [COLOR_W-1:0] ramp1_q, ramp_d;
   logic               hit1_q, hit_d;

   // Stage 2: final colour
   logic               hs2_q, vs2_q;
   logic [COLOR_W-1:0] red_q, green_q, blue_q;
   logic [COLOR_W-1:0] red_d, green_d, blue_d;
   logic [2:0]         bar_on;

   logic [10:0] h;
   logic [10:0] v;
   logic        frame_start;

   assign h = vga.hcount;
   assign v = {1'b0, vga.vcount};

   // vs1_q doubles as the registered copy of vsync_n for edge detection.
   assign frame_start = vs1_q & ~vga.vsync_n;

   // NOTE: every variable written in always_comb gets a default first so no latch is inferred.
   always_comb begin
      pending_d = pending_q;
      active_d  = active_q;
      frame_d   = frame_q;
      box_x_d   = box_x_q;
      box_y_d   = box_y_q;
      if (vga.mode_load) pending_d = pattern_e'(vga.mode);
      if (frame_start) begin
         active_d = pending_d;
         frame_d  = frame_q + 8'd1;
         box_x_d  = step_axis(box_x_q, X_STEP, X_MAX);
         box_y_d  = step_axis(box_y_q, Y_STEP, Y_MAX);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         frame_q   <= '0;
         active_q  <= PAT_BARS;
         pending_q <= PAT_BARS;
         box_x_q   <= '0;
         box_y_q   <= '0;
      end else begin
         frame_q   <= frame_d;
         active_q  <= active_d;
         pending_q <= pending_d;
         box_x_q   <= box_x_d;
         box_y_q   <= box_y_d;
      end
   end

   generate
      if (COLOR_W >= 4) begin : g_ramp_ext
         assign ramp_d = COLOR_W'(h[9:6]);
      end else begin : g_ramp_trunc
         assign ramp_d = h[9 -: COLOR_W];
      end
   endgenerate

   always_comb begin
      bar_d = 3'd0;
      for (int i = 1; i < 8; i++) begin
         if (h >= 11'(i * 100)) bar_d = 3'(i);
      end
      chk_d = h[5] ^ v[5];
      hit_d = (h >= box_x_q.pos) && (h < box_x_q.pos + BOX_W) &&
              (v >= box_y_q.pos) && (v < box_y_q.pos + BOX_W);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de1_q   <= 1'b0;
         hs1_q   <= 1'b1;
         vs1_q   <= 1'b1;
         bar1_q  <= '0;
         chk1_q  <= 1'b0;
         ramp1_q <= '0;
         hit1_q  <= 1'b0;
      end else begin
         de1_q   <= vga.de;
         hs1_q   <= vga.hsync_n;
         vs1_q   <= vga.vsync_n;
         bar1_q  <= bar_d;
         chk1_q  <= chk_d;
         ramp1_q <= ramp_d;
         hit1_q  <= hit_d;
      end
   end

   // Bar order: white, yellow, cyan, green, magenta, red, blue, black as {R,G,B} on-bits.
   always_comb begin
      red_d   = '0;
      green_d = '0;
      blue_d  = '0;
      unique case (bar1_q)
         3'd0:    bar_on = 3'b111;
         3'd1:    bar_on = 3'b110;
         3'd2:    bar_on = 3'b011;
         3'd3:    bar_on = 3'b010;
         3'd4:    bar_on = 3'b101;
         3'd5:    bar_on = 3'b100;
         3'd6:    bar_on = 3'b001;
         default: bar_on = 3'b000;
      endcase
      if (de1_q) begin
         unique case (active_q)
            PAT_BARS: begin
               red_d   = {COLOR_W{bar_on[2]}};
               green_d = {COLOR_W{bar_on[1]}};
               blue_d  = {COLOR_W{bar_on[0]}};
            end
            PAT_CHECK: begin
               red_d   = {COLOR_W{chk1_q}};
               green_d = {COLOR_W{chk1_q}};
               blue_d  = {COLOR_W{chk1_q}};
            end
            PAT_RAMP: begin
               red_d   = ramp1_q;
               green_d = ramp1_q;
               blue_d  = ramp1_q;
            end
            PAT_BOX: begin
               red_d   = hit1_q ? FULL : '0;
               green_d = hit1_q ? FULL : '0;
               blue_d  = FULL;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         hs2_q   <= 1'b1;
         vs2_q   <= 1'b1;
         red_q   <= '0;
         green_q <= '0;
         blue_q  <= '0;
      end else begin
         hs2_q   <= hs1_q;
         vs2_q   <= vs1_q;
         red_q   <= red_d;
         green_q <= green_d;
         blue_q  <= blue_d;
      end
   end

   assign vga.red         = red_q;
   assign vga.green       = green_q;
   assign vga.blue        = blue_q;
   assign vga.hsync_out_n = hs2_q;
   assign vga.vsync_out_n = vs2_q;
   assign vga.frame_count = frame_q;
   assign vga.active_mode = active_q;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Bench for vga_pattern_gen: the driver pushes each pixel's expected RGB/syncs into a queue
// due two clocks later; an independent monitor pops and compares on the falling edge.
module tb_vga_pattern_gen;

   localparam int CW = 4;
   localparam logic [11:0] WHITE   = 12'hFFF;
   localparam logic [11:0] YELLOW  = 12'hFF0;
   localparam logic [11:0] BLUE    = 12'h00F;
   localparam logic [11:0] BLACK   = 12'h000;
   localparam logic [11:0] BAR_RGB [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0,
                                            12'hF0F, 12'hF00, 12'h00F, 12'h000};

   typedef struct {
      logic [11:0] rgb;
      logic        hs;
      logic        vs;
      int          due;
      logic [95:0] tag;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   // Reference notion of the DUT's frame-level state
   int   m_active = 0;
   int   m_pending = 0;
   int   b_cnt = 0;
   logic m_vs_prev = 1'b1;

   vga_pattern_if #(.COLOR_W(CW)) vga ();

   vga_pattern_gen #(.COLOR_W(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .vga   (vga)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input logic [95:0] name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %0s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [11:0] exp_rgb(input int h, input int v, input logic d);
      int         bar;
      logic [3:0] lvl;
      if (!d) return BLACK;
      case (m_active)
         0: begin
            bar = h / 100;
            if (bar > 7) bar = 7;
            return BAR_RGB[bar];
         end
         1: return ((((h / 32) + (v / 32)) % 2) == 1) ? WHITE : BLACK;
         2: begin
            lvl = 4'(h / 64);
            return {lvl, lvl, lvl};
         end
         default: return BLUE;
      endcase
   endfunction

   // Apply one pixel's inputs for a full cycle and schedule its expected output.
   task automatic drive(input int h, input int v, input logic d, input logic hs, input logic vs,
                        input logic ml, input int m, input logic [11:0] xrgb,
                        input logic [95:0] tag);
      @(negedge clk);
      vga.hcount    = 11'(h);
      vga.vcount    = 10'(v);
      vga.de        = d;
      vga.hsync_n   = hs;
      vga.vsync_n   = vs;
      vga.mode      = 2'(m);
      vga.mode_load = ml;
      if (m_vs_prev && !vs) begin
         b_cnt++;
         m_active = ml ? m : m_pending;
      end
      if (ml) m_pending = m;
      m_vs_prev = vs;
      exp_q.push_back('{xrgb, hs, vs, cyc + 2, tag});
   endtask

   task automatic pix(input int h, input int v, input logic d, input logic hs, input logic vs,
                      input logic [95:0] tag);
      drive(h, v, d, hs, vs, 1'b0, 0, exp_rgb(h, v, d), tag);
   endtask

   task automatic probe(input int h, input int v, input logic [11:0] rgb, input logic [95:0] tag);
      drive(h, v, 1'b1, 1'b1, 1'b1, 1'b0, 0, rgb, tag);
   endtask

   task automatic idle(input logic vs);
      drive(0, 0, 1'b0, 1'b1, vs, 1'b0, 0, BLACK, "blank");
   endtask

   task automatic frame_pulse();
      idle(1'b1);
      idle(1'b0);
   endtask

   always @(negedge clk) begin
      while (exp_q.size() > 0 && exp_q[0].due <= cyc) begin
         exp_t e;
         e = exp_q.pop_front();
         if (e.due < cyc) begin
            checks++;
            errors++;
            $display("FAIL %0s: output due cycle %0d not compared until %0d", e.tag, e.due, cyc);
         end else begin
            check(e.tag, {18'h0, vga.red, vga.green, vga.blue, vga.hsync_out_n, vga.vsync_out_n},
                  {18'h0, e.rgb, e.hs, e.vs});
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
      $fatal(1, "watchdog expired");
   end

   initial begin
      vga.hcount    = '0;
      vga.vcount    = '0;
      vga.de        = 1'b0;
      vga.hsync_n   = 1'b1;
      vga.vsync_n   = 1'b1;
      vga.mode      = 2'd0;
      vga.mode_load = 1'b0;
      repeat (3) @(negedge clk);
      check("reset state", {8'h0, vga.red, vga.green, vga.blue, vga.hsync_out_n, vga.vsync_out_n,
                            vga.frame_count, vga.active_mode}, {8'h0, 12'h000, 2'b11, 8'h00, 2'd0});
      rst_n = 1'b1;

      // Colour bars across a visible line; one de-low pixel must blank only itself.
      for (int h = 0; h < 800; h++) pix(h, 10, h != 450, 1'b1, 1'b1, "bars");
      probe(99, 10, WHITE, "bars h99");
      probe(100, 10, YELLOW, "bars h100");
      probe(799, 10, BLACK, "bars h799");

      // Horizontal blanking with the sync pulse at 840..967.
      for (int h = 800; h < 1056; h++) pix(h, 10, 1'b0, !(h >= 840 && h <= 967), 1'b1, "hblank");

      // Checker requested mid-frame: must not take effect until the next vsync fall.
      for (int h = 0; h < 20; h++) pix(h, 11, 1'b1, 1'b1, 1'b1, "bars pre");
      drive(200, 11, 1'b1, 1'b1, 1'b1, 1'b1, 1, exp_rgb(200, 11, 1'b1), "load chk");
      for (int h = 201; h < 220; h++) pix(h, 11, 1'b1, 1'b1, 1'b1, "bars post");
      check("mode held mid-frame", 32'(vga.active_mode), 32'd0);
      idle(1'b1);
      idle(1'b0);
      check("mode in boundary cycle", 32'(vga.active_mode), 32'd0);
      idle(1'b0);
      check("mode after boundary", 32'(vga.active_mode), 32'd1);
      check("frame_count 1", 32'(vga.frame_count), 32'd1);
      for (int h = 0; h < 128; h++) pix(h, 0, 1'b1, 1'b1, 1'b1, "checker");
      probe(32, 0, WHITE, "chk 32,0");
      probe(31, 0, BLACK, "chk 31,0");
      probe(32, 32, BLACK, "chk 32,32");
      probe(0, 32, WHITE, "chk 0,32");

      // Grey ramp.
      drive(0, 5, 1'b0, 1'b1, 1'b1, 1'b1, 2, BLACK, "load ramp");
      frame_pulse();
      for (int h = 0; h < 800; h++) pix(h, 5, 1'b1, 1'b1, 1'b1, "ramp");
      probe(64, 5, 12'h111, "ramp h64");
      probe(799, 5, 12'hCCC, "ramp h799");

      // Bouncing box: 4 px per frame to the right edge at frame 184, then back.
      drive(0, 5, 1'b0, 1'b1, 1'b1, 1'b1, 3, BLACK, "load box");
      while (b_cnt < 184) frame_pulse();
      probe(735, 368, BLUE, "box184 x735");
      probe(736, 368, WHITE, "box184 x736");
      probe(799, 368, WHITE, "box184 x799");
      probe(736, 367, BLUE, "box184 y367");
      probe(799, 431, WHITE, "box184 y431");
      probe(736, 432, BLUE, "box184 y432");
      frame_pulse();
      probe(731, 370, BLUE, "box185 x731");
      probe(732, 370, WHITE, "box185 x732");
      probe(795, 370, WHITE, "box185 x795");
      probe(796, 370, BLUE, "box185 x796");
      frame_pulse();
      probe(727, 372, BLUE, "box186 x727");
      probe(728, 372, WHITE, "box186 x728");
      probe(791, 435, WHITE, "box186 x791");
      probe(792, 372, BLUE, "box186 x792");
      check("frame_count 186", 32'(vga.frame_count), 32'd186);

      // Counter wrap, with a mode strobe landing exactly on the wrapping boundary.
      while (b_cnt < 255) frame_pulse();
      idle(1'b1);
      check("frame_count 255", 32'(vga.frame_count), 32'd255);
      drive(0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0, BLACK, "coincident");
      check("mode at coincident edge", 32'(vga.active_mode), 32'd3);
      idle(1'b0);
      check("frame_count wrap", 32'(vga.frame_count), 32'd0);
      check("coincident mode", 32'(vga.active_mode), 32'd0);
      probe(150, 10, YELLOW, "bars after wrap");
      probe(650, 10, BLUE, "bars h650");
      probe(700, 10, BLACK, "bars h700");

      // Asynchronous reset in the middle of a white run.
      for (int h = 0; h < 40; h++) pix(h, 10, 1'b1, 1'b1, 1'b1, "pre reset");
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      exp_q.delete();
      m_active  = 0;
      m_pending = 0;
      m_vs_prev = 1'b1;
      #1;
      check("async reset", {8'h0, vga.red, vga.green, vga.blue, vga.hsync_out_n, vga.vsync_out_n,
                            vga.frame_count, vga.active_mode}, {8'h0, 12'h000, 2'b11, 8'h00, 2'd0});
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int h = 90; h < 110; h++) pix(h, 10, 1'b1, 1'b1, 1'b1, "post reset");
      probe(150, 10, YELLOW, "post reset h150");
      idle(1'b1);

      for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
      if (exp_q.size() > 0) begin
         checks++;
         errors++;
         $display("FAIL drain: %0d expected outputs never compared", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
